fu_result_arbiter: RTL and testbench
====================================

Name: fu_result_arbiter

Overview:
- Shares the common data bus (CDB) and the ROB write port between NUM_FU functional-unit output stages, e.g. the select FU, ALU FUs and the load FU.
- Each FU output stage holds a finished result and raises a CDB request and/or a ROB request. The arbiter grants at most one requester per channel per cycle, using an independent round-robin pointer per channel.
- The winning payload is registered onto the shared bus.
- The block sits between the FU output stages and the CDB/ROB.

Parameters:
- NUM_FU, 4, number of requesting FUs (2..8).
- ID_W, 4, ROB id width.
- VAL_W, 8, result value width.
- FLAG_W, 8, flags width.
- WBS_W, 8, writeback-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous squash: drops registered outputs, grants nothing this cycle.
- cdb_req  in  NUM_FU  per-FU CDB request (FU's cdb_transmit_out).
- cdb_req_id  in  NUM_FU x ID_W  per-FU ROB id for the broadcast.
- cdb_req_val  in  NUM_FU x VAL_W  per-FU broadcast value.
- cdb_grant  out  NUM_FU  one-hot CDB grant (drives FU cdb_transmit), combinational.
- cdb_valid  out  1  registered CDB broadcast valid.
- cdb_id  out  ID_W  registered broadcast ROB id.
- cdb_val  out  VAL_W  registered broadcast value.
- rob_req  in  NUM_FU  per-FU ROB request (FU's rob_transmit_out).
- rob_req_robid  in  NUM_FU x ID_W  per-FU ROB id.
- rob_req_flags  in  NUM_FU x FLAG_W  per-FU flags.
- rob_req_wbs  in  NUM_FU x WBS_W  per-FU writeback select.
- rob_req_value  in  NUM_FU x VAL_W  per-FU result value.
- rob_grant  out  NUM_FU  one-hot ROB grant (drives FU rob_transmit), combinational.
- rob_valid  out  1  registered ROB write valid.
- rob_ready  in  1  ROB accepts the current rob_* output this cycle.
- rob_robid  out  ID_W  registered ROB id.
- rob_flags  out  FLAG_W  registered flags.
- rob_wbs  out  WBS_W  registered writeback select.
- rob_value  out  VAL_W  registered result value.

Behaviour:
- Reset:
  - cdb_valid=0, rob_valid=0, all payload outputs 0.
  - Both round-robin pointers = 0.
  - Grants are forced to 0 while rst=1.
- Round-robin:
  - Winner = first set request bit at index ptr, ptr+1, ... wrapping modulo NUM_FU.
  - On a grant to index w, ptr <= (w+1) mod NUM_FU; w=NUM_FU-1 wraps to 0.
  - No grant leaves ptr unchanged.
- Grant handshake:
  - A grant is a single-cycle pulse in the same cycle as the request.
  - The FU treats a grant as a completed transfer and must deassert or replace its request next cycle.
  - An ungranted request must be held stable. The arbiter does not check this.
- CDB channel:
  - No backpressure; grants whenever any cdb_req is set.
  - Next cycle cdb_valid=1 with the winner's id/val. Latency 1 cycle.
  - No request: cdb_valid=0 next cycle and cdb_id/cdb_val hold their old values.
  - Back-to-back grants every cycle are allowed.
- ROB channel:
  - load_ok = !rob_valid || rob_ready.
  - Grant only when load_ok and some rob_req is set; the winner loads into the rob_* registers, rob_valid=1.
  - rob_valid && rob_ready && no new grant: rob_valid<=0.
  - rob_valid && !rob_ready: outputs hold, rob_grant=0, rob pointer frozen.
- Channel independence: CDB and ROB arbitrate independently. The same FU may win both in one cycle; different FUs may win each.
- flush:
  - Grants forced to 0, cdb_valid<=0, rob_valid<=0.
  - Pointers unchanged; payload registers unchanged.
  - rst has priority over flush.
- Reset or flush mid-transfer: a held, unaccepted ROB entry is discarded. The FU keeps its request and is re-arbitrated after rst/flush deassert.
- Grant vectors are always one-hot or zero; no X on grants when requests are 0.

Decomposition:
- Package fu_arb_pkg:
  - Default width localparams (ID_W, VAL_W, FLAG_W, WBS_W).
  - Struct cdb_pkt_t {id, val}.
  - Struct rob_pkt_t {robid, flags, wbs, value}.
- Sub-module rr_arbiter:
  - Parameter N; inputs clk, rst, req[N], advance (grant accepted); outputs grant[N] one-hot, grant_idx.
  - Contains the pointer; instantiated twice (CDB with advance=1, ROB with advance=load_ok).
- Top-level holds the two payload muxes and output registers.

Test Plan:
- Reset: rst high 2 cycles with all req=1 → grants 0, cdb_valid=0, rob_valid=0. First cycle after rst falls, cdb_req=4'b1111 → cdb_grant=4'b0001, next cycle cdb_id=req id of FU0.
- Fairness/wrap: cdb_req=4'b1111 held 5 cycles → grants 0001,0010,0100,1000,0001. cdb_val stream matches FU0..FU3,FU0 values (e.g. 8'h10,8'h20,8'h30,8'h40,8'h10).
- Skip: ptr=1, cdb_req=4'b1001 → grant 1000, then ptr=0 → next grant 0001.
- ROB backpressure: FU2 rob_req with robid=4'd7, value=8'hA5, rob_ready=0 for 3 cycles → rob_valid=1 holding 7/A5, FU1 rob_req gets no grant. rob_ready=1 → same cycle FU1 granted, next cycle rob_robid=FU1 id.
- Concurrent channels: FU0 cdb_req and FU3 rob_req in same cycle → cdb_grant=0001 and rob_grant=1000 simultaneously. FU1 both → both grants to FU1.
- Flush: rob_valid=1 stalled, flush=1 with cdb_req=4'b0100 → no grants, next cycle cdb_valid=0, rob_valid=0, pointers unchanged. After flush, FU2 granted.

Source files
------------

// File: rtl/fu_arb_pkg.sv
// Shared types for the FU result arbiter: default payload widths and the
// CDB / ROB payload records at those default widths.
// Ports: none (package only).
package fu_arb_pkg;

   localparam int ID_W   = 4;
   localparam int VAL_W  = 8;
   localparam int FLAG_W = 8;
   localparam int WBS_W  = 8;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [VAL_W-1:0] val;
   } cdb_pkt_t;

   typedef struct packed {
      logic [ID_W-1:0]   robid;
      logic [FLAG_W-1:0] flags;
      logic [WBS_W-1:0]  wbs;
      logic [VAL_W-1:0]  value;
   } rob_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own pointer; combinational one-hot grant.
// Ports: clk, rst (sync, active-high), req[N], advance (grant may be issued
// and accepted this cycle), grant[N] one-hot, grant_idx, grant_vld.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;

   // Scan from the pointer upward, wrapping modulo N; first set request wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         if (!grant_vld && req[j]) begin
            grant_vld = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
      // Reset or a blocked channel issues nothing, so the pointer stays put.
      if (rst || !advance) begin
         grant     = '0;
         grant_idx = '0;
         grant_vld = 1'b0;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_vld) begin
         ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/fu_result_arbiter.sv
// Arbitrates NUM_FU result stages onto the CDB (no backpressure) and the ROB
// write port (held while !rob_ready); winners registered, 1-cycle latency.
// Ports: clk, rst, flush; cdb_req*/cdb_grant/cdb_* out; rob_req*/rob_grant/rob_ready/rob_* out.
module fu_result_arbiter #(
   parameter int NUM_FU = 4,
   parameter int ID_W   = fu_arb_pkg::ID_W,
   parameter int VAL_W  = fu_arb_pkg::VAL_W,
   parameter int FLAG_W = fu_arb_pkg::FLAG_W,
   parameter int WBS_W  = fu_arb_pkg::WBS_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [NUM_FU-1:0]              cdb_req,
   input  logic [NUM_FU-1:0][ID_W-1:0]    cdb_req_id,
   input  logic [NUM_FU-1:0][VAL_W-1:0]   cdb_req_val,
   output logic [NUM_FU-1:0]              cdb_grant,
   output logic                           cdb_valid,
   output logic [ID_W-1:0]                cdb_id,
   output logic [VAL_W-1:0]               cdb_val,
   input  logic [NUM_FU-1:0]              rob_req,
   input  logic [NUM_FU-1:0][ID_W-1:0]    rob_req_robid,
   input  logic [NUM_FU-1:0][FLAG_W-1:0]  rob_req_flags,
   input  logic [NUM_FU-1:0][WBS_W-1:0]   rob_req_wbs,
   input  logic [NUM_FU-1:0][VAL_W-1:0]   rob_req_value,
   output logic [NUM_FU-1:0]              rob_grant,
   output logic                           rob_valid,
   input  logic                           rob_ready,
   output logic [ID_W-1:0]                rob_robid,
   output logic [FLAG_W-1:0]              rob_flags,
   output logic [WBS_W-1:0]               rob_wbs,
   output logic [VAL_W-1:0]               rob_value
);

   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   // Same layout as the package records, sized by this instance's parameters.
   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [VAL_W-1:0] val;
   } cdb_word_t;

   typedef struct packed {
      logic [ID_W-1:0]   robid;
      logic [FLAG_W-1:0] flags;
      logic [WBS_W-1:0]  wbs;
      logic [VAL_W-1:0]  value;
   } rob_word_t;

   cdb_word_t        cdb_pkt_q, cdb_pkt_d;
   rob_word_t        rob_pkt_q, rob_pkt_d;
   logic             cdb_valid_q, cdb_valid_d;
   logic             rob_valid_q, rob_valid_d;
   logic [IDX_W-1:0] cdb_idx, rob_idx;
   logic             cdb_win, rob_win;
   logic             load_ok;

   // The ROB output register may be reloaded when empty or being drained now.
   assign load_ok = !rob_valid_q || rob_ready;

   rr_arbiter #(.N(NUM_FU), .IDX_W(IDX_W)) u_cdb_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (cdb_req),
      .advance   (!flush),
      .grant     (cdb_grant),
      .grant_idx (cdb_idx),
      .grant_vld (cdb_win)
   );

   rr_arbiter #(.N(NUM_FU), .IDX_W(IDX_W)) u_rob_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (rob_req),
      .advance   (!flush && load_ok),
      .grant     (rob_grant),
      .grant_idx (rob_idx),
      .grant_vld (rob_win)
   );

   // Flush suppresses the grants above, so it only needs to clear the valids
   // here; payloads keep their last contents.
   always_comb begin
      cdb_valid_d = cdb_win;
      cdb_pkt_d   = cdb_pkt_q;
      if (cdb_win) begin
         cdb_pkt_d.id  = cdb_req_id[cdb_idx];
         cdb_pkt_d.val = cdb_req_val[cdb_idx];
      end

      rob_valid_d = rob_valid_q;
      rob_pkt_d   = rob_pkt_q;
      if (flush) begin
         rob_valid_d = 1'b0;
      end else if (rob_win) begin
         rob_valid_d     = 1'b1;
         rob_pkt_d.robid = rob_req_robid[rob_idx];
         rob_pkt_d.flags = rob_req_flags[rob_idx];
         rob_pkt_d.wbs   = rob_req_wbs[rob_idx];
         rob_pkt_d.value = rob_req_value[rob_idx];
      end else if (rob_ready) begin
         rob_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid_q <= 1'b0;
         cdb_pkt_q   <= '0;
         rob_valid_q <= 1'b0;
         rob_pkt_q   <= '0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_pkt_q   <= cdb_pkt_d;
         rob_valid_q <= rob_valid_d;
         rob_pkt_q   <= rob_pkt_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_id    = cdb_pkt_q.id;
   assign cdb_val   = cdb_pkt_q.val;
   assign rob_valid = rob_valid_q;
   assign rob_robid = rob_pkt_q.robid;
   assign rob_flags = rob_pkt_q.flags;
   assign rob_wbs   = rob_pkt_q.wbs;
   assign rob_value = rob_pkt_q.value;

endmodule

// File: tb/tb_fu_result_arbiter.sv
// Directed bench for fu_result_arbiter: a per-cycle vector table plus a short
// hand-written rst/flush priority sequence.
// Ports: none (top-level bench).
module tb_fu_result_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, flush, rob_ready;
   logic [N-1:0]        cdb_req, rob_req;
   logic [N-1:0][3:0]   cdb_req_id, rob_req_robid;
   logic [N-1:0][7:0]   cdb_req_val, rob_req_flags, rob_req_wbs, rob_req_value;
   logic [N-1:0]        cdb_grant, rob_grant;
   logic                cdb_valid, rob_valid;
   logic [3:0]          cdb_id, rob_robid;
   logic [7:0]          cdb_val, rob_flags, rob_wbs, rob_value;

   fu_result_arbiter #(.NUM_FU(N)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .cdb_req(cdb_req), .cdb_req_id(cdb_req_id), .cdb_req_val(cdb_req_val),
      .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
      .rob_req(rob_req), .rob_req_robid(rob_req_robid), .rob_req_flags(rob_req_flags),
      .rob_req_wbs(rob_req_wbs), .rob_req_value(rob_req_value),
      .rob_grant(rob_grant), .rob_valid(rob_valid), .rob_ready(rob_ready),
      .rob_robid(rob_robid), .rob_flags(rob_flags), .rob_wbs(rob_wbs), .rob_value(rob_value)
   );

   typedef struct {
      logic       rst, flush;
      logic [3:0] cdb_req, rob_req;
      logic       rdy;
      logic [3:0] e_cgnt, e_rgnt;
      logic       e_cv, e_rv;
      int         e_cfu, e_rfu;  // FU whose payload should sit in the output regs; -1 = zeros
   } vec_t;

   vec_t vecs[23];
   int checks = 0;
   int failures = 0;

   // Fixed per-FU payloads so each registered output identifies its source FU.
   const logic [3:0] c_id  [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
   const logic [7:0] c_val [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
   const logic [3:0] r_id  [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
   const logic [7:0] r_val [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
      end
   endtask

   task automatic chk_regs(input int row, input logic ecv, input logic erv, input int cfu, input int rfu);
      chk("cdb_valid", row, 32'(cdb_valid), 32'(ecv));
      chk("rob_valid", row, 32'(rob_valid), 32'(erv));
      chk("cdb_id",    row, 32'(cdb_id),    (cfu < 0) ? 32'd0 : 32'(c_id[cfu]));
      chk("cdb_val",   row, 32'(cdb_val),   (cfu < 0) ? 32'd0 : 32'(c_val[cfu]));
      chk("rob_robid", row, 32'(rob_robid), (rfu < 0) ? 32'd0 : 32'(r_id[rfu]));
      chk("rob_value", row, 32'(rob_value), (rfu < 0) ? 32'd0 : 32'(r_val[rfu]));
      chk("rob_flags", row, 32'(rob_flags), (rfu < 0) ? 32'd0 : 32'(8'hF0 + 8'(rfu)));
      chk("rob_wbs",   row, 32'(rob_wbs),   (rfu < 0) ? 32'd0 : 32'(8'h80 + 8'(rfu)));
   endtask

   task automatic set_row(input int k, input logic r, input logic f, input logic [3:0] cr,
                          input logic [3:0] rr, input logic rd, input logic [3:0] cg,
                          input logic [3:0] rg, input logic cv, input logic rv,
                          input int cfu, input int rfu);
      vecs[k].rst = r;  vecs[k].flush = f; vecs[k].cdb_req = cr; vecs[k].rob_req = rr;
      vecs[k].rdy = rd; vecs[k].e_cgnt = cg; vecs[k].e_rgnt = rg;
      vecs[k].e_cv = cv; vecs[k].e_rv = rv; vecs[k].e_cfu = cfu; vecs[k].e_rfu = rfu;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         cdb_req_id[i]    = c_id[i];
         cdb_req_val[i]   = c_val[i];
         rob_req_robid[i] = r_id[i];
         rob_req_value[i] = r_val[i];
         rob_req_flags[i] = 8'hF0 + 8'(i);
         rob_req_wbs[i]   = 8'h80 + 8'(i);
      end
      rst = 1'b1; flush = 1'b0; rob_ready = 1'b1; cdb_req = '0; rob_req = '0;

      //          rst flush cdb    rob    rdy  cgnt   rgnt   cv rv cfu rfu
      set_row( 0, 1, 0, 4'hF, 4'hF, 1, 4'h0, 4'h0, 0, 0, -1, -1); // reset, all requesting
      set_row( 1, 1, 0, 4'hF, 4'hF, 1, 4'h0, 4'h0, 0, 0, -1, -1);
      set_row( 2, 0, 0, 4'hF, 4'h0, 1, 4'h1, 4'h0, 1, 0,  0, -1); // rotation 0,1,2,3,0
      set_row( 3, 0, 0, 4'hF, 4'h0, 1, 4'h2, 4'h0, 1, 0,  1, -1);
      set_row( 4, 0, 0, 4'hF, 4'h0, 1, 4'h4, 4'h0, 1, 0,  2, -1);
      set_row( 5, 0, 0, 4'hF, 4'h0, 1, 4'h8, 4'h0, 1, 0,  3, -1);
      set_row( 6, 0, 0, 4'hF, 4'h0, 1, 4'h1, 4'h0, 1, 0,  0, -1);
      set_row( 7, 0, 0, 4'h9, 4'h0, 1, 4'h8, 4'h0, 1, 0,  3, -1); // ptr=1 skips to FU3
      set_row( 8, 0, 0, 4'h9, 4'h0, 1, 4'h1, 4'h0, 1, 0,  0, -1); // wrap to FU0
      set_row( 9, 0, 0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0,  0, -1); // idle: cdb payload holds
      set_row(10, 0, 0, 4'h0, 4'h4, 0, 4'h0, 4'h4, 0, 1,  0,  2); // FU2 loads 7/A5
      set_row(11, 0, 0, 4'h0, 4'h2, 0, 4'h0, 4'h0, 0, 1,  0,  2); // stalled: FU1 waits
      set_row(12, 0, 0, 4'h0, 4'h2, 0, 4'h0, 4'h0, 0, 1,  0,  2);
      set_row(13, 0, 0, 4'h0, 4'h2, 0, 4'h0, 4'h0, 0, 1,  0,  2);
      set_row(14, 0, 0, 4'h0, 4'h2, 1, 4'h0, 4'h2, 0, 1,  0,  1); // drain + reload same cycle
      set_row(15, 0, 0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0,  0,  1); // drain, no reload
      set_row(16, 0, 0, 4'h1, 4'h8, 1, 4'h1, 4'h8, 1, 1,  0,  3); // independent winners
      set_row(17, 0, 0, 4'h2, 4'h2, 1, 4'h2, 4'h2, 1, 1,  1,  1); // FU1 wins both
      set_row(18, 0, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 1,  1,  1); // ROB stalled
      set_row(19, 0, 1, 4'h4, 4'h1, 0, 4'h0, 4'h0, 0, 0,  1,  1); // flush drops entry
      set_row(20, 0, 0, 4'h4, 4'h1, 0, 4'h4, 4'h1, 1, 1,  2,  0); // pointers kept: FU2 / FU0
      set_row(21, 1, 0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 0, 0, -1, -1); // reset mid-transfer
      set_row(22, 0, 0, 4'hF, 4'hF, 1, 4'h1, 4'h1, 1, 1,  0,  0); // pointers back at 0

      for (int k = 0; k < 23; k++) begin
         @(negedge clk);
         rst = vecs[k].rst; flush = vecs[k].flush; rob_ready = vecs[k].rdy;
         cdb_req = vecs[k].cdb_req; rob_req = vecs[k].rob_req;
         #1;
         chk("cdb_grant", k, 32'(cdb_grant), 32'(vecs[k].e_cgnt));
         chk("rob_grant", k, 32'(rob_grant), 32'(vecs[k].e_rgnt));
         @(posedge clk); #1;
         chk_regs(k, vecs[k].e_cv, vecs[k].e_rv, vecs[k].e_cfu, vecs[k].e_rfu);
      end

      // rst and flush together: reset wins and clears payloads.
      @(negedge clk);
      rst = 1'b1; flush = 1'b1; cdb_req = 4'hF; rob_req = 4'hF; rob_ready = 1'b1;
      #1;
      chk("rstflush_cgnt", 100, 32'(cdb_grant), 32'h0);
      chk("rstflush_rgnt", 100, 32'(rob_grant), 32'h0);
      @(posedge clk); #1;
      chk_regs(100, 1'b0, 1'b0, -1, -1);
      // flush alone still blocks grants.
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("flush_cgnt", 101, 32'(cdb_grant), 32'h0);
      chk("flush_rgnt", 101, 32'(rob_grant), 32'h0);
      @(posedge clk); #1;
      chk_regs(101, 1'b0, 1'b0, -1, -1);
      // Release: first grants come from pointer 0.
      @(negedge clk);
      flush = 1'b0; cdb_req = 4'hC; rob_req = 4'h6;
      #1;
      chk("post_cgnt", 102, 32'(cdb_grant), 32'h4);
      chk("post_rgnt", 102, 32'(rob_grant), 32'h2);
      @(posedge clk); #1;
      chk_regs(102, 1'b1, 1'b1, 2, 1);
      @(negedge clk);
      cdb_req = 4'h0; rob_req = 4'h0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
